// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage RISC-V pipeline.
// Shadows the destination/op type of the EX and MEM instructions to resolve ID-stage dependencies.
module hazard_fwd_unit #(
    parameter int RegAddrW = 5,
    parameter int OptW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rs1use_ID,
    input  logic                rs2use_ID,
    input  logic [OptW-1:0]     hazard_optype_ID,
    input  logic [RegAddrW-1:0] rd_ID,
    input  logic [RegAddrW-1:0] rs1_ID,
    input  logic [RegAddrW-1:0] rs2_ID,
    input  logic                Branch_ID,
    output logic                PC_EN_IF,
    output logic                reg_FD_EN,
    output logic                reg_FD_flush,
    output logic                reg_DE_flush,
    output logic [1:0]          forward_ctrl_A,
    output logic [1:0]          forward_ctrl_B,
    output logic                forward_ctrl_ls
);

    localparam logic [OptW-1:0] OPT_NONE  = OptW'(0);
    localparam logic [OptW-1:0] OPT_ALU   = OptW'(1);
    localparam logic [OptW-1:0] OPT_LOAD  = OptW'(2);
    localparam logic [OptW-1:0] OPT_STORE = OptW'(3);

    logic [OptW-1:0]     opt_EX, opt_MEM;
    logic [RegAddrW-1:0] rd_EX, rd_MEM;
    logic                st_fwd_EX, st_fwd_MEM;

    logic a_ex, a_mem, b_ex, b_mem;
    logic load_use, st_fwd_ID;

    // EX has priority: a source matching EX never looks at MEM, even if EX is a stalled load.
    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic mem_m,
                                           input logic [OptW-1:0] oe, input logic [OptW-1:0] om);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_m) begin
            if (oe == OPT_ALU) sel = 2'b01;
        end else if (mem_m) begin
            if (om == OPT_ALU)       sel = 2'b10;
            else if (om == OPT_LOAD) sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        a_ex  = rs1use_ID && (rs1_ID != '0) && (rs1_ID == rd_EX)
                && ((opt_EX == OPT_ALU) || (opt_EX == OPT_LOAD));
        a_mem = rs1use_ID && (rs1_ID != '0) && (rs1_ID == rd_MEM)
                && ((opt_MEM == OPT_ALU) || (opt_MEM == OPT_LOAD));
        b_ex  = rs2use_ID && (rs2_ID != '0) && (rs2_ID == rd_EX)
                && ((opt_EX == OPT_ALU) || (opt_EX == OPT_LOAD));
        b_mem = rs2use_ID && (rs2_ID != '0) && (rs2_ID == rd_MEM)
                && ((opt_MEM == OPT_ALU) || (opt_MEM == OPT_LOAD));

        // A store only needing the load result as its data can pick it up later in MEM.
        load_use  = (opt_EX == OPT_LOAD) &&
                    (a_ex || (b_ex && (hazard_optype_ID != OPT_STORE)));
        st_fwd_ID = (hazard_optype_ID == OPT_STORE) && (opt_EX == OPT_LOAD) && b_ex && !load_use;

        forward_ctrl_A  = fwd_sel(a_ex, a_mem, opt_EX, opt_MEM);
        forward_ctrl_B  = fwd_sel(b_ex, b_mem, opt_EX, opt_MEM);
        forward_ctrl_ls = st_fwd_MEM;
    end

    // A stall overrides a branch: the branch operands are not valid until the load reaches MEM.
    always_comb begin
        PC_EN_IF     = 1'b1;
        reg_FD_EN    = 1'b1;
        reg_FD_flush = 1'b0;
        reg_DE_flush = 1'b0;
        if (load_use) begin
            PC_EN_IF     = 1'b0;
            reg_FD_EN    = 1'b0;
            reg_DE_flush = 1'b1;
        end else if (Branch_ID) begin
            reg_FD_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opt_EX     <= OPT_NONE;
            rd_EX      <= '0;
            opt_MEM    <= OPT_NONE;
            rd_MEM     <= '0;
            st_fwd_EX  <= 1'b0;
            st_fwd_MEM <= 1'b0;
        end else begin
            opt_MEM    <= opt_EX;
            rd_MEM     <= rd_EX;
            st_fwd_MEM <= st_fwd_EX;
            if (reg_DE_flush) begin
                opt_EX    <= OPT_NONE;
                rd_EX     <= '0;
                st_fwd_EX <= 1'b0;
            end else begin
                opt_EX    <= hazard_optype_ID;
                rd_EX     <= rd_ID;
                st_fwd_EX <= st_fwd_ID;
            end
        end
    end

endmodule
